// File: rtl/i2s_buf_ctrl_pkg.sv
// Shared sizing constants for the I2S TX/RX sample buffers.
// Pure declarations: no logic, no latency, no flow control.
package i2s_pkg;
  localparam int I2S_FIFO_DEPTH = 4;
  localparam int I2S_FIFO_AW    = 2;
  localparam int I2S_DW         = 32;
  localparam int I2S_SPACE_W    = 3;
endpackage

// File: rtl/i2s_buf_ctrl_if.sv
// Buffer-stage bus: APB side, serialiser and deserialiser strobes plus FIFO status.
// master drives requests/data; slave (the buffer controller) returns status and head words.
interface i2s_buf_ctrl_if;
  import i2s_pkg::*;

  logic                   fifo_reset;
  logic                   tx_enable;
  logic                   rx_enable;
  logic                   wr_tx_buf;
  logic [I2S_DW-1:0]      PWDATA;
  logic [I2S_SPACE_W-1:0] tx_fifo_space;
  logic                   tx_fifo_empty;
  logic                   tx_fifo_full;
  logic                   tx_rd_req;
  logic [I2S_DW-1:0]      tx_rd_data;
  logic                   tx_underrun;
  logic                   rx_wr_req;
  logic [I2S_DW-1:0]      rx_wr_data;
  logic                   rd_rx_buf;
  logic [I2S_DW-1:0]      rd_buf_rdata;
  logic [I2S_SPACE_W-1:0] rx_fifo_space;
  logic                   rx_fifo_empty;
  logic                   rx_fifo_full;
  logic                   rx_overrun;

  modport master (
    output fifo_reset, tx_enable, rx_enable, wr_tx_buf, PWDATA,
    output tx_rd_req, rx_wr_req, rx_wr_data, rd_rx_buf,
    input  tx_fifo_space, tx_fifo_empty, tx_fifo_full, tx_rd_data, tx_underrun,
    input  rd_buf_rdata, rx_fifo_space, rx_fifo_empty, rx_fifo_full, rx_overrun
  );

  modport slave (
    input  fifo_reset, tx_enable, rx_enable, wr_tx_buf, PWDATA,
    input  tx_rd_req, rx_wr_req, rx_wr_data, rd_rx_buf,
    output tx_fifo_space, tx_fifo_empty, tx_fifo_full, tx_rd_data, tx_underrun,
    output rd_buf_rdata, rx_fifo_space, rx_fifo_empty, rx_fifo_full, rx_overrun
  );
endinterface

// File: rtl/i2s_buf_ctrl_sync_fifo.sv
// Generic show-ahead circular FIFO; status and head reflect a push/pop one edge later.
// Push on full and pop on empty are dropped; flush clears pointers and blocks both sides.
module i2s_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign count_o = count_q;
  // Forced to zero when empty so stale storage never leaks out.
  assign head_o  = empty_o ? '0 : mem[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= data_i;
  end
endmodule

// File: rtl/i2s_buf_ctrl.sv
// TX/RX sample buffers between APB registers and the I2S serial engine, with enable gating.
// Status/head valid the cycle after a push/pop; underrun/overrun are registered 1-cycle pulses.
module i2s_buf_ctrl
  import i2s_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESETn,
  i2s_buf_ctrl_if.slave    bus
);
  localparam logic [I2S_SPACE_W-1:0] SPACE_MAX = I2S_SPACE_W'(I2S_FIFO_DEPTH);

  logic [I2S_FIFO_AW:0] tx_count, rx_count;
  logic                 tx_pop, rx_push;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;

  assign tx_pop  = bus.tx_rd_req & bus.tx_enable;
  assign rx_push = bus.rx_wr_req & bus.rx_enable;

  i2s_sync_fifo #(.DEPTH(I2S_FIFO_DEPTH), .DW(I2S_DW), .AW(I2S_FIFO_AW)) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (bus.wr_tx_buf),
    .pop_i   (tx_pop),
    .flush_i (bus.fifo_reset),
    .data_i  (bus.PWDATA),
    .head_o  (bus.tx_rd_data),
    .count_o (tx_count),
    .empty_o (bus.tx_fifo_empty),
    .full_o  (bus.tx_fifo_full)
  );

  // A pop on full in the same cycle does not make room: the FIFO judges push on pre-edge state.
  i2s_sync_fifo #(.DEPTH(I2S_FIFO_DEPTH), .DW(I2S_DW), .AW(I2S_FIFO_AW)) u_rx_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (rx_push),
    .pop_i   (bus.rd_rx_buf),
    .flush_i (bus.fifo_reset),
    .data_i  (bus.rx_wr_data),
    .head_o  (bus.rd_buf_rdata),
    .count_o (rx_count),
    .empty_o (bus.rx_fifo_empty),
    .full_o  (bus.rx_fifo_full)
  );

  assign bus.tx_fifo_space = SPACE_MAX - tx_count;
  assign bus.rx_fifo_space = SPACE_MAX - rx_count;

  assign underrun_d = tx_pop  & bus.tx_fifo_empty & ~bus.fifo_reset;
  assign overrun_d  = rx_push & bus.rx_fifo_full  & ~bus.fifo_reset;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_underrun = underrun_q;
  assign bus.rx_overrun  = overrun_q;
endmodule

// File: tb/tb_i2s_buf_ctrl.sv
// Directed self-checking bench for i2s_buf_ctrl: reset, TX fill/drain, underrun, RX overrun, wrap, flush.
module tb_i2s_buf_ctrl;
  logic PCLK = 1'b0;
  logic PRESETn;
  int   checks = 0;
  int   errors = 0;

  i2s_buf_ctrl_if bus();

  i2s_buf_ctrl dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fifo_reset = 1'b0;
    bus.wr_tx_buf  = 1'b0;
    bus.PWDATA     = '0;
    bus.tx_rd_req  = 1'b0;
    bus.rx_wr_req  = 1'b0;
    bus.rx_wr_data = '0;
    bus.rd_rx_buf  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.tx_enable = 1'b0;
    bus.rx_enable = 1'b0;
    PRESETn = 1'b0;
    #23;
    PRESETn = 1'b1;
    tick();
    tick();
    checks++; if (bus.tx_fifo_space !== 3'd4) begin errors++; $display("FAIL reset_tx_space: got %0d expected 4", bus.tx_fifo_space); end
    checks++; if (bus.tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b expected 1", bus.tx_fifo_empty); end
    checks++; if (bus.tx_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", bus.tx_fifo_full); end
    checks++; if (bus.tx_rd_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", bus.tx_rd_data); end
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus.tx_underrun); end
    checks++; if (bus.rx_fifo_space !== 3'd4) begin errors++; $display("FAIL reset_rx_space: got %0d expected 4", bus.rx_fifo_space); end
    checks++; if (bus.rx_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", bus.rx_fifo_empty); end
    checks++; if (bus.rx_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full: got %b expected 0", bus.rx_fifo_full); end
    checks++; if (bus.rd_buf_rdata !== 32'h0) begin errors++; $display("FAIL reset_rx_data: got %0h expected 0", bus.rd_buf_rdata); end
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.rx_overrun); end
  endtask

  task automatic test_tx_fill_drain();
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      bus.wr_tx_buf = 1'b1;
      bus.PWDATA    = words[i];
      tick();
      bus.wr_tx_buf = 1'b0;
      checks++; if (bus.tx_fifo_space !== 3'(3 - i)) begin errors++; $display("FAIL tx_fill_space[%0d]: got %0d expected %0d", i, bus.tx_fifo_space, 3 - i); end
    end
    checks++; if (bus.tx_fifo_full !== 1'b1) begin errors++; $display("FAIL tx_full: got %b expected 1", bus.tx_fifo_full); end
    checks++; if (bus.tx_rd_data !== 32'h11) begin errors++; $display("FAIL tx_head_after_fill: got %0h expected 11", bus.tx_rd_data); end
    bus.tx_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.tx_rd_data !== words[i]) begin errors++; $display("FAIL tx_drain_data[%0d]: got %0h expected %0h", i, bus.tx_rd_data, words[i]); end
      bus.tx_rd_req = 1'b1;
      tick();
      bus.tx_rd_req = 1'b0;
      checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL tx_drain_underrun[%0d]: got %b expected 0", i, bus.tx_underrun); end
    end
    checks++; if (bus.tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL tx_empty_after_drain: got %b expected 1", bus.tx_fifo_empty); end
    checks++; if (bus.tx_rd_data !== 32'h0) begin errors++; $display("FAIL tx_data_zero_empty: got %0h expected 0", bus.tx_rd_data); end
  endtask

  task automatic test_underrun_with_push();
    bus.tx_enable = 1'b1;
    bus.tx_rd_req = 1'b1;
    bus.wr_tx_buf = 1'b1;
    bus.PWDATA    = 32'hA5;
    tick();
    clear_inputs();
    checks++; if (bus.tx_underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b expected 1", bus.tx_underrun); end
    checks++; if (bus.tx_fifo_space !== 3'd3) begin errors++; $display("FAIL underrun_push_space: got %0d expected 3", bus.tx_fifo_space); end
    checks++; if (bus.tx_rd_data !== 32'hA5) begin errors++; $display("FAIL underrun_push_data: got %0h expected a5", bus.tx_rd_data); end
    tick();
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL underrun_single_cycle: got %b expected 0", bus.tx_underrun); end
    bus.tx_rd_req = 1'b1;
    tick();
    bus.tx_rd_req = 1'b0;
    checks++; if (bus.tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL underrun_cleanup_empty: got %b expected 1", bus.tx_fifo_empty); end
  endtask

  task automatic test_rx_overrun();
    bus.rx_enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.rx_wr_req  = 1'b1;
      bus.rx_wr_data = 32'(i);
      tick();
      bus.rx_wr_req = 1'b0;
      if (i == 4) begin
        checks++; if (bus.rx_fifo_full !== 1'b1) begin errors++; $display("FAIL rx_full_after_4: got %b expected 1", bus.rx_fifo_full); end
        checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_no_overrun_4: got %b expected 0", bus.rx_overrun); end
      end
    end
    checks++; if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL rx_overrun_pulse: got %b expected 1", bus.rx_overrun); end
    checks++; if (bus.rd_buf_rdata !== 32'h1) begin errors++; $display("FAIL rx_head_after_overrun: got %0h expected 1", bus.rd_buf_rdata); end
    tick();
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL rx_overrun_single_cycle: got %b expected 0", bus.rx_overrun); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.rd_buf_rdata !== 32'(i)) begin errors++; $display("FAIL rx_pop_data[%0d]: got %0h expected %0h", i, bus.rd_buf_rdata, i); end
      bus.rd_rx_buf = 1'b1;
      tick();
      bus.rd_rx_buf = 1'b0;
    end
    checks++; if (bus.rx_fifo_empty !== 1'b1) begin errors++; $display("FAIL rx_empty_after_pops: got %b expected 1", bus.rx_fifo_empty); end
    checks++; if (bus.rd_buf_rdata !== 32'h0) begin errors++; $display("FAIL rx_dropped_word_hidden: got %0h expected 0", bus.rd_buf_rdata); end
  endtask

  task automatic test_back_to_back_wrap();
    bus.tx_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.wr_tx_buf = 1'b1;
      bus.PWDATA    = 32'h100 + 32'(i);
      tick();
    end
    bus.wr_tx_buf = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus.tx_rd_data !== 32'h100 + 32'(k)) begin errors++; $display("FAIL wrap_head[%0d]: got %0h expected %0h", k, bus.tx_rd_data, 32'h100 + 32'(k)); end
      bus.wr_tx_buf = 1'b1;
      bus.PWDATA    = 32'h102 + 32'(k);
      bus.tx_rd_req = 1'b1;
      tick();
      checks++; if (bus.tx_fifo_space !== 3'd2) begin errors++; $display("FAIL wrap_space[%0d]: got %0d expected 2", k, bus.tx_fifo_space); end
    end
    bus.wr_tx_buf = 1'b0;
    for (int k = 10; k < 12; k++) begin
      checks++; if (bus.tx_rd_data !== 32'h100 + 32'(k)) begin errors++; $display("FAIL wrap_tail[%0d]: got %0h expected %0h", k, bus.tx_rd_data, 32'h100 + 32'(k)); end
      tick();
    end
    bus.tx_rd_req = 1'b0;
    checks++; if (bus.tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", bus.tx_fifo_empty); end
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL wrap_no_underrun: got %b expected 0", bus.tx_underrun); end
  endtask

  task automatic test_fifo_reset();
    bus.tx_enable = 1'b1;
    bus.rx_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_tx_buf  = (i < 3);
      bus.PWDATA     = 32'h31 + 32'(i);
      bus.rx_wr_req  = 1'b1;
      bus.rx_wr_data = 32'h51 + 32'(i);
      tick();
    end
    clear_inputs();
    checks++; if (bus.tx_fifo_space !== 3'd1) begin errors++; $display("FAIL flush_pre_tx_space: got %0d expected 1", bus.tx_fifo_space); end
    checks++; if (bus.rx_fifo_full !== 1'b1) begin errors++; $display("FAIL flush_pre_rx_full: got %b expected 1", bus.rx_fifo_full); end
    bus.fifo_reset = 1'b1;
    bus.tx_rd_req  = 1'b1;
    bus.rx_wr_req  = 1'b1;
    bus.rx_wr_data = 32'hEE;
    bus.wr_tx_buf  = 1'b1;
    bus.PWDATA     = 32'hDD;
    tick();
    clear_inputs();
    checks++; if (bus.tx_fifo_space !== 3'd4) begin errors++; $display("FAIL flush_tx_space: got %0d expected 4", bus.tx_fifo_space); end
    checks++; if (bus.rx_fifo_space !== 3'd4) begin errors++; $display("FAIL flush_rx_space: got %0d expected 4", bus.rx_fifo_space); end
    checks++; if (bus.tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_tx_empty: got %b expected 1", bus.tx_fifo_empty); end
    checks++; if (bus.rx_fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_rx_empty: got %b expected 1", bus.rx_fifo_empty); end
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL flush_no_underrun: got %b expected 0", bus.tx_underrun); end
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL flush_no_overrun: got %b expected 0", bus.rx_overrun); end
    checks++; if (bus.tx_rd_data !== 32'h0) begin errors++; $display("FAIL flush_tx_data: got %0h expected 0", bus.tx_rd_data); end
    bus.tx_enable = 1'b0;
    bus.tx_rd_req = 1'b1;
    tick();
    bus.tx_rd_req = 1'b0;
    checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL disabled_no_underrun: got %b expected 0", bus.tx_underrun); end
    bus.wr_tx_buf = 1'b1;
    bus.PWDATA    = 32'h77;
    tick();
    bus.wr_tx_buf = 1'b0;
    checks++; if (bus.tx_rd_data !== 32'h77) begin errors++; $display("FAIL post_flush_push_data: got %0h expected 77", bus.tx_rd_data); end
    bus.tx_rd_req = 1'b1;
    tick();
    bus.tx_rd_req = 1'b0;
    checks++; if (bus.tx_fifo_space !== 3'd3) begin errors++; $display("FAIL disabled_pop_ignored: got %0d expected 3", bus.tx_fifo_space); end
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_underrun_with_push();
    test_rx_overrun();
    test_back_to_back_wrap();
    test_fifo_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
